// File: rtl/permutation_output_buffer_pkg.sv
// rtl/permutation_output_buffer_pkg.sv - shared constants for the permutation output buffer
package permutation_output_buffer_pkg;

    localparam int BOT_WIDTH          = 128;
    localparam int SERIES_LENGTH      = 42;
    localparam int SERIES_CNT_WIDTH   = 6;
    localparam int DEPTH_LOG2         = 7;
    localparam int ALMOST_FULL_MARGIN = 48;

endpackage

// File: rtl/permutation_output_buffer_if.sv
// rtl/permutation_output_buffer_if.sv - generator-side and consumer-side streams of the output buffer
interface permutation_output_buffer_if #(
    parameter int BOT_WIDTH = permutation_output_buffer_pkg::BOT_WIDTH
);

    logic [BOT_WIDTH-1:0] botIn;
    logic                 botInValid;
    logic                 botSeriesFinishedIn;
    logic                 slowDown;

    logic [BOT_WIDTH-1:0] botOut;
    logic                 botOutValid;
    logic                 botOutLast;
    logic                 botOutReady;

    modport master (
        output botIn, botInValid, botSeriesFinishedIn, botOutReady,
        input  slowDown, botOut, botOutValid, botOutLast
    );

    modport slave (
        input  botIn, botInValid, botSeriesFinishedIn, botOutReady,
        output slowDown, botOut, botOutValid, botOutLast
    );

endinterface

// File: rtl/perm_output_fifo_ram.sv
// rtl/perm_output_fifo_ram.sv - simple dual-port RAM with a registered 1-cycle read port
module perm_output_fifo_ram #(
    parameter int WIDTH      = 129,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wrEn,
    input  logic [ADDR_WIDTH-1:0] wrAddr,
    input  logic [WIDTH-1:0]      wrData,
    input  logic                  rdEn,
    input  logic [ADDR_WIDTH-1:0] rdAddr,
    output logic [WIDTH-1:0]      rdData
);

    logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    // Only the read register is cleared; it doubles as the show-ahead output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdData <= '0;
        end else if (rdEn) begin
            rdData <= mem[rdAddr];
        end
    end

endmodule

// File: rtl/permutation_output_buffer.sv
// rtl/permutation_output_buffer.sv - buffers permuted bots, throttles the generator, checks series lengths
module permutation_output_buffer #(
    parameter int BOT_WIDTH          = permutation_output_buffer_pkg::BOT_WIDTH,
    parameter int DEPTH_LOG2         = permutation_output_buffer_pkg::DEPTH_LOG2,
    parameter int ALMOST_FULL_MARGIN = permutation_output_buffer_pkg::ALMOST_FULL_MARGIN,
    parameter int SERIES_LENGTH      = permutation_output_buffer_pkg::SERIES_LENGTH
) (
    input  logic                       clk,
    input  logic                       rst,
    permutation_output_buffer_if.slave bus,
    output logic [DEPTH_LOG2:0]        occupancy,
    output logic [31:0]                completedSeries,
    output logic                       overflow,
    output logic                       seriesLengthError
);

    import permutation_output_buffer_pkg::*;

    localparam int OCC_W = DEPTH_LOG2 + 1;
    localparam int SCN_W = SERIES_CNT_WIDTH + 1;

    localparam logic [OCC_W-1:0]            FULL_LEVEL     = OCC_W'((1 << DEPTH_LOG2) + 1);
    localparam logic [OCC_W-1:0]            MARGIN         = OCC_W'(ALMOST_FULL_MARGIN);
    localparam logic [OCC_W-1:0]            OCC_ONE        = OCC_W'(1);
    localparam logic [DEPTH_LOG2-1:0]       PTR_ONE        = DEPTH_LOG2'(1);
    localparam logic [SCN_W-1:0]            SERIES_LEN_C   = SCN_W'(SERIES_LENGTH);
    localparam logic [SERIES_CNT_WIDTH-1:0] SERIES_CNT_MAX = '1;

    logic [DEPTH_LOG2-1:0]       wrPtr;
    logic [DEPTH_LOG2-1:0]       rdPtr;
    logic                        outValid;
    logic                        slowDownReg;
    logic [BOT_WIDTH:0]          rdData;
    logic [SERIES_CNT_WIDTH-1:0] seriesCnt;

    logic             full;
    logic             wrEn;
    logic             pop;
    logic             rdEn;
    logic [OCC_W-1:0] ramCount;
    logic [OCC_W-1:0] freeEntries;
    logic [SCN_W-1:0] seriesCntNext;

    // Occupancy includes the output register, so RAM fill is what is left once it is valid.
    assign full          = (occupancy == FULL_LEVEL);
    assign wrEn          = bus.botInValid && !full;
    assign pop           = outValid && bus.botOutReady;
    assign ramCount      = occupancy - OCC_W'(outValid);
    assign rdEn          = (!outValid || pop) && (ramCount != '0);
    assign freeEntries   = FULL_LEVEL - occupancy;
    assign seriesCntNext = SCN_W'(seriesCnt) + SCN_W'(1);

    perm_output_fifo_ram #(
        .WIDTH      (BOT_WIDTH + 1),
        .ADDR_WIDTH (DEPTH_LOG2)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .wrEn   (wrEn),
        .wrAddr (wrPtr),
        .wrData ({bus.botSeriesFinishedIn, bus.botIn}),
        .rdEn   (rdEn),
        .rdAddr (rdPtr),
        .rdData (rdData)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            outValid  <= 1'b0;
            occupancy <= '0;
        end else begin
            if (wrEn) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            if (rdEn) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
            if (rdEn) begin
                outValid <= 1'b1;
            end else if (pop) begin
                outValid <= 1'b0;
            end
            case ({wrEn, pop})
                2'b10:   occupancy <= occupancy + OCC_ONE;
                2'b01:   occupancy <= occupancy - OCC_ONE;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // slowDown only blocks the next series, so the margin covers one full series in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            slowDownReg     <= 1'b0;
            completedSeries <= '0;
            overflow        <= 1'b0;
        end else begin
            slowDownReg <= (freeEntries <= MARGIN);
            if (pop && rdData[BOT_WIDTH]) begin
                completedSeries <= completedSeries + 32'd1;
            end
            if (bus.botInValid && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seriesCnt         <= '0;
            seriesLengthError <= 1'b0;
        end else if (wrEn) begin
            if (bus.botSeriesFinishedIn) begin
                if (seriesCntNext != SERIES_LEN_C) begin
                    seriesLengthError <= 1'b1;
                end
                seriesCnt <= '0;
            end else if (seriesCntNext >= SCN_W'(SERIES_CNT_MAX)) begin
                seriesLengthError <= 1'b1;
                seriesCnt         <= SERIES_CNT_MAX;
            end else begin
                seriesCnt <= seriesCntNext[SERIES_CNT_WIDTH-1:0];
            end
        end
    end

    assign bus.botOut      = rdData[BOT_WIDTH-1:0];
    assign bus.botOutLast  = rdData[BOT_WIDTH];
    assign bus.botOutValid = outValid;
    assign bus.slowDown    = slowDownReg;

endmodule

// File: tb/tb_permutation_output_buffer.sv
// tb/tb_permutation_output_buffer.sv - directed self-checking bench for permutation_output_buffer
module tb_permutation_output_buffer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    permutation_output_buffer_if bus ();

    logic [7:0]  occupancy;
    logic [31:0] completedSeries;
    logic        overflow;
    logic        seriesLengthError;

    permutation_output_buffer dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (bus),
        .occupancy         (occupancy),
        .completedSeries   (completedSeries),
        .overflow          (overflow),
        .seriesLengthError (seriesLengthError)
    );

    int errors = 0;
    int checks = 0;
    logic [128:0] popQ [$];

    // One cycle: drive inputs at the falling edge, log any pop the next rising edge will perform.
    task automatic step(input logic v, input logic [127:0] d, input logic f, input logic r);
        bus.botInValid          = v;
        bus.botIn               = d;
        bus.botSeriesFinishedIn = f;
        bus.botOutReady         = r;
        if (!rst && bus.botOutValid && r) popQ.push_back({bus.botOutLast, bus.botOut});
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b1, '1, 1'b1, 1'b1);
        rst = 1'b0;
        popQ.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b1, 128'hDEAD, 1'b1, 1'b1);
        step(1'b1, 128'hBEEF, 1'b0, 1'b1);
        checks++; if (bus.botOutValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.botOutValid); end
        checks++; if (bus.botOutLast !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", bus.botOutLast); end
        checks++; if (bus.botOut !== 128'd0) begin errors++; $display("FAIL reset_botOut: got %h expected 0", bus.botOut); end
        checks++; if (bus.slowDown !== 1'b0) begin errors++; $display("FAIL reset_slowDown: got %b expected 0", bus.slowDown); end
        checks++; if (occupancy !== 8'd0) begin errors++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        checks++; if (completedSeries !== 32'd0) begin errors++; $display("FAIL reset_completed: got %0d expected 0", completedSeries); end
        checks++; if ({overflow, seriesLengthError} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {overflow, seriesLengthError}); end
        rst = 1'b0;
        popQ.delete();
    endtask

    task automatic test_single_series();
        logic [128:0] exp;
        logic [128:0] got;
        do_reset();
        step(1'b1, 128'd1, 1'b0, 1'b1);
        checks++; if (bus.botOutValid !== 1'b0) begin errors++; $display("FAIL latency_early: got %b expected 0", bus.botOutValid); end
        step(1'b1, 128'd2, 1'b0, 1'b1);
        checks++; if ({bus.botOutValid, bus.botOut} !== {1'b1, 128'd1}) begin errors++; $display("FAIL latency_2cyc: got valid=%b data=%0d expected valid=1 data=1", bus.botOutValid, bus.botOut); end
        for (int n = 3; n <= 42; n++) step(1'b1, 128'(n), n == 42, 1'b1);
        repeat (6) step(1'b0, '0, 1'b0, 1'b1);
        checks++; if (popQ.size() !== 42) begin errors++; $display("FAIL single_count: got %0d expected 42", popQ.size()); end
        for (int i = 0; i < 42; i++) begin
            exp = {i == 41, 128'(i + 1)};
            got = (i < popQ.size()) ? popQ[i] : '1;
            checks++; if (got !== exp) begin errors++; $display("FAIL single_data[%0d]: got %h expected %h", i, got, exp); end
        end
        checks++; if (completedSeries !== 32'd1) begin errors++; $display("FAIL single_completed: got %0d expected 1", completedSeries); end
        checks++; if ({overflow, seriesLengthError, occupancy} !== 10'd0) begin errors++; $display("FAIL single_flags: got ovf=%b err=%b occ=%0d expected 0 0 0", overflow, seriesLengthError, occupancy); end
    endtask

    task automatic test_slowdown();
        logic [128:0] exp;
        logic [128:0] got;
        do_reset();
        for (int n = 1; n <= 126; n++) begin
            step(1'b1, 128'(n), (n % 42) == 0, 1'b0);
            if (n == 81) begin
                checks++; if ({occupancy, bus.slowDown} !== {8'd81, 1'b0}) begin errors++; $display("FAIL slow_at81: got occ=%0d slow=%b expected occ=81 slow=0", occupancy, bus.slowDown); end
            end
            if (n == 82) begin
                checks++; if (bus.slowDown !== 1'b1) begin errors++; $display("FAIL slow_rise: got %b expected 1", bus.slowDown); end
            end
        end
        checks++; if ({occupancy, overflow} !== {8'd126, 1'b0}) begin errors++; $display("FAIL slow_filled: got occ=%0d ovf=%b expected occ=126 ovf=0", occupancy, overflow); end
        for (int j = 1; j <= 129; j++) begin
            step(1'b0, '0, 1'b0, 1'b1);
            if (j == 46) begin
                checks++; if ({occupancy, bus.slowDown} !== {8'd80, 1'b1}) begin errors++; $display("FAIL slow_hold: got occ=%0d slow=%b expected occ=80 slow=1", occupancy, bus.slowDown); end
            end
            if (j == 47) begin
                checks++; if (bus.slowDown !== 1'b0) begin errors++; $display("FAIL slow_fall: got %b expected 0", bus.slowDown); end
            end
        end
        checks++; if (popQ.size() !== 126) begin errors++; $display("FAIL slow_count: got %0d expected 126", popQ.size()); end
        for (int i = 0; i < 126; i++) begin
            exp = {((i + 1) % 42) == 0, 128'(i + 1)};
            got = (i < popQ.size()) ? popQ[i] : '1;
            checks++; if (got !== exp) begin errors++; $display("FAIL slow_data[%0d]: got %h expected %h", i, got, exp); end
        end
        checks++; if ({completedSeries, seriesLengthError} !== {32'd3, 1'b0}) begin errors++; $display("FAIL slow_end: got done=%0d err=%b expected done=3 err=0", completedSeries, seriesLengthError); end
    endtask

    task automatic test_overflow();
        logic [128:0] exp;
        logic [128:0] got;
        do_reset();
        for (int n = 1; n <= 140; n++) begin
            step(1'b1, 128'(n), (n % 42) == 0, 1'b0);
            if (n == 129) begin
                checks++; if ({occupancy, overflow} !== {8'd129, 1'b0}) begin errors++; $display("FAIL ovf_at129: got occ=%0d ovf=%b expected occ=129 ovf=0", occupancy, overflow); end
            end
            if (n == 130) begin
                checks++; if ({occupancy, overflow} !== {8'd129, 1'b1}) begin errors++; $display("FAIL ovf_at130: got occ=%0d ovf=%b expected occ=129 ovf=1", occupancy, overflow); end
            end
        end
        step(1'b1, 128'd999, 1'b0, 1'b1);
        checks++; if (occupancy !== 8'd128) begin errors++; $display("FAIL ovf_pop_same_cycle: got occ=%0d expected 128", occupancy); end
        repeat (132) step(1'b0, '0, 1'b0, 1'b1);
        checks++; if (popQ.size() !== 129) begin errors++; $display("FAIL ovf_count: got %0d expected 129", popQ.size()); end
        for (int i = 0; i < 129; i++) begin
            exp = {((i + 1) % 42) == 0, 128'(i + 1)};
            got = (i < popQ.size()) ? popQ[i] : '1;
            checks++; if (got !== exp) begin errors++; $display("FAIL ovf_data[%0d]: got %h expected %h", i, got, exp); end
        end
        checks++; if ({overflow, seriesLengthError, occupancy} !== {1'b1, 1'b0, 8'd0}) begin errors++; $display("FAIL ovf_end: got ovf=%b err=%b occ=%0d expected 1 0 0", overflow, seriesLengthError, occupancy); end
    endtask

    task automatic test_length_error();
        logic [128:0] exp;
        logic [128:0] got;
        do_reset();
        for (int n = 1; n <= 41; n++) begin
            step(1'b1, 128'(n), n == 41, 1'b1);
            if (n == 40) begin
                checks++; if (seriesLengthError !== 1'b0) begin errors++; $display("FAIL len_early: got %b expected 0", seriesLengthError); end
            end
        end
        checks++; if (seriesLengthError !== 1'b1) begin errors++; $display("FAIL len_short: got %b expected 1", seriesLengthError); end
        for (int n = 1; n <= 42; n++) step(1'b1, 128'(100 + n), n == 42, 1'b1);
        repeat (6) step(1'b0, '0, 1'b0, 1'b1);
        checks++; if (seriesLengthError !== 1'b1) begin errors++; $display("FAIL len_sticky: got %b expected 1", seriesLengthError); end
        checks++; if (popQ.size() !== 83) begin errors++; $display("FAIL len_count: got %0d expected 83", popQ.size()); end
        for (int i = 0; i < 83; i++) begin
            exp = (i < 41) ? {i == 40, 128'(i + 1)} : {i == 82, 128'(100 + i - 40)};
            got = (i < popQ.size()) ? popQ[i] : '1;
            checks++; if (got !== exp) begin errors++; $display("FAIL len_data[%0d]: got %h expected %h", i, got, exp); end
        end
        checks++; if (completedSeries !== 32'd2) begin errors++; $display("FAIL len_completed: got %0d expected 2", completedSeries); end
    endtask

    task automatic test_back_to_back();
        logic [128:0] exp;
        logic [128:0] got;
        logic [128:0] prevOut;
        logic         prevStall;
        logic         r;
        int           nextVal;
        do_reset();
        prevStall = 1'b0;
        prevOut   = '0;
        nextVal   = 1;
        for (int c = 0; c < 400; c++) begin
            r = (c % 2) == 0;
            if (prevStall) begin
                got = {bus.botOutLast, bus.botOut};
                checks++; if (bus.botOutValid !== 1'b1 || got !== prevOut) begin errors++; $display("FAIL stall_hold: got valid=%b data=%h expected valid=1 data=%h", bus.botOutValid, got, prevOut); end
            end
            prevStall = bus.botOutValid && !r;
            prevOut   = {bus.botOutLast, bus.botOut};
            if (nextVal <= 126) begin
                step(1'b1, 128'(nextVal), (nextVal % 42) == 0, r);
                nextVal++;
            end else begin
                step(1'b0, '0, 1'b0, r);
            end
        end
        checks++; if (popQ.size() !== 126) begin errors++; $display("FAIL b2b_count: got %0d expected 126", popQ.size()); end
        for (int i = 0; i < 126; i++) begin
            exp = {((i + 1) % 42) == 0, 128'(i + 1)};
            got = (i < popQ.size()) ? popQ[i] : '1;
            checks++; if (got !== exp) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, got, exp); end
        end
        checks++; if ({occupancy, completedSeries} !== {8'd0, 32'd3}) begin errors++; $display("FAIL b2b_end: got occ=%0d done=%0d expected occ=0 done=3", occupancy, completedSeries); end
        checks++; if ({overflow, seriesLengthError} !== 2'b00) begin errors++; $display("FAIL b2b_flags: got %b expected 00", {overflow, seriesLengthError}); end
    endtask

    task automatic test_mid_reset();
        logic [128:0] got;
        do_reset();
        for (int n = 1; n <= 42; n++) step(1'b1, 128'(n), n == 42, 1'b1);
        repeat (6) step(1'b0, '0, 1'b0, 1'b1);
        for (int n = 1; n <= 20; n++) step(1'b1, 128'(50 + n), 1'b0, 1'b0);
        checks++; if ({occupancy, completedSeries} !== {8'd20, 32'd1}) begin errors++; $display("FAIL mid_before: got occ=%0d done=%0d expected occ=20 done=1", occupancy, completedSeries); end
        rst = 1'b1;
        step(1'b1, 128'd77, 1'b1, 1'b1);
        rst = 1'b0;
        checks++; if ({bus.botOutValid, bus.slowDown, occupancy} !== 10'd0) begin errors++; $display("FAIL mid_cleared: got valid=%b slow=%b occ=%0d expected 0 0 0", bus.botOutValid, bus.slowDown, occupancy); end
        checks++; if ({completedSeries, overflow, seriesLengthError} !== 34'd0) begin errors++; $display("FAIL mid_counters: got done=%0d ovf=%b err=%b expected 0 0 0", completedSeries, overflow, seriesLengthError); end
        popQ.delete();
        for (int n = 1; n <= 42; n++) step(1'b1, 128'(200 + n), n == 42, 1'b1);
        repeat (6) step(1'b0, '0, 1'b0, 1'b1);
        checks++; if (seriesLengthError !== 1'b0) begin errors++; $display("FAIL mid_fresh_err: got %b expected 0", seriesLengthError); end
        checks++; if (completedSeries !== 32'd1) begin errors++; $display("FAIL mid_fresh_done: got %0d expected 1", completedSeries); end
        checks++; if (popQ.size() !== 42) begin errors++; $display("FAIL mid_fresh_count: got %0d expected 42", popQ.size()); end
        got = (popQ.size() > 0) ? popQ[0] : '1;
        checks++; if (got !== {1'b0, 128'd201}) begin errors++; $display("FAIL mid_fresh_first: got %h expected %h", got, {1'b0, 128'd201}); end
        got = (popQ.size() > 41) ? popQ[41] : '1;
        checks++; if (got !== {1'b1, 128'd242}) begin errors++; $display("FAIL mid_fresh_last: got %h expected %h", got, {1'b1, 128'd242}); end
    endtask

    initial begin
        test_reset();
        test_single_series();
        test_slowdown();
        test_overflow();
        test_length_error();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/permutation_output_buffer.md
Name: permutation_output_buffer

Overview:
- Sits directly downstream of one permutation generator lane, behind multiPermutationGenerator67.
- Captures each permuted bot together with its series-end flag into an on-chip FIFO.
- Presents the buffered stream to the compute pipeline through a valid/ready handshake.
- Drives the generator's slowDown input, and checks that every series has the expected length.

Parameters:
- BOT_WIDTH, 128: width of one bot.
- DEPTH_LOG2, 7: log2 of FIFO depth, so 128 entries.
- ALMOST_FULL_MARGIN, 48: free-entry threshold for slowDown. It must be at least SERIES_LENGTH plus the generator request latency, because slowDown only stops the next series and the current series still completes.
- SERIES_LENGTH, 42: bots per series (7*6 permutations).

Ports:
- clk  in  1  clock.
- rst  in  1  reset (see Behaviour).
- botIn  in  BOT_WIDTH  permuted bot from the generator.
- botInValid  in  1  botIn is valid this cycle.
- botSeriesFinishedIn  in  1  botIn is the last bot of its series. Only meaningful when botInValid is high.
- slowDown  out  1  registered. Generator must not start a new series while it is high.
- botOut  out  BOT_WIDTH  head-of-FIFO bot.
- botOutValid  out  1  botOut is valid.
- botOutLast  out  1  botOut closes a series.
- botOutReady  in  1  consumer accepts botOut this cycle.
- occupancy  out  DEPTH_LOG2+1  entries held, including the output register.
- completedSeries  out  32  number of series whose last bot has been popped. Wraps modulo 2^32.
- overflow  out  1  sticky flag: a write was dropped.
- seriesLengthError  out  1  sticky flag: a series had a length other than SERIES_LENGTH.

Behaviour:
- Reset: reset rst, synchronous, active-high; clock clk.
  - While rst is high, all of the following are 0: pointers, output register, botOutValid, botOutLast, slowDown, occupancy, completedSeries, overflow, seriesLengthError, series counter.
  - Asserting rst mid-operation discards all buffered data and any partial-series count. Inputs present during rst are ignored.
- Storage: RAM of 2^DEPTH_LOG2 words, each word {botSeriesFinishedIn, botIn}, plus a one-entry registered output stage (show-ahead).
- Write:
  - The entry is written on any cycle with botInValid=1 and not full, where full = occupancy == 2^DEPTH_LOG2 + 1.
  - If full, the write is dropped and overflow is set. Full is evaluated before a same-cycle pop, so a write on a full buffer is dropped even if a pop also occurs.
  - botSeriesFinishedIn with botInValid=0 is ignored.
- Read:
  - A pop happens when botOutValid && botOutReady.
  - The output register refills from RAM when it is empty or being popped and the RAM is non-empty.
  - RAM read latency is 1 cycle, giving a write-to-botOutValid latency of exactly 2 cycles into an empty buffer.
  - Throughput is one pop per cycle while the buffer is non-empty.
  - botOut and botOutLast hold steady while botOutValid && !botOutReady.
- Occupancy counting: occupancy increments on an accepted write, decrements on a pop, and is unchanged when both happen in the same cycle.
- slowDown: registered each cycle as (2^DEPTH_LOG2 + 1 - occupancy) <= ALMOST_FULL_MARGIN, i.e. asserted when free space is at or below the margin.
- Series check:
  - A 6-bit counter counts accepted valid bots.
  - On an accepted write with botSeriesFinishedIn=1: if counter+1 != SERIES_LENGTH, set seriesLengthError; then clear the counter.
  - If the counter would reach 63 without a finish flag, set seriesLengthError and saturate the counter.
  - Dropped writes are not counted; their loss is already flagged by overflow.
- completedSeries increments on a pop with botOutLast=1.
- Wrap: pointers are DEPTH_LOG2 bits wide and wrap naturally. Full/empty are derived from the occupancy counter, not from pointer comparison.

Decomposition:
- Shared package constants: BOT_WIDTH=128, SERIES_LENGTH=42. Also the series-length check width (6 bits) as a localparam.
- One sub-module, perm_output_fifo_ram: simple dual-port RAM, write port plus registered read port, 1-cycle latency, parameterised width/depth, no reset on contents. All control and pointers stay in the top module.

Test Plan:
1. Reset, then write 42 bots (values 1..42, finish flag on 42) with botOutReady=1.
   Expect: the first botOutValid 2 cycles after the first write; 42 pops in order; botOutLast only on value 42; completedSeries=1; no flags set.
2. Hold botOutReady=0 and write 3 full series (126 bots).
   Expect: slowDown rises once occupancy reaches 81, i.e. free space 48; no overflow; then drain all 126 bots in order, with slowDown deasserting once free space exceeds 48.
3. botOutReady=0 and write 140 bots.
   Expect: writes 130..140 dropped; overflow=1; occupancy=129; the drained sequence is exactly 1..129.
4. Series of 41 bots with the finish flag on the 41st.
   Expect: seriesLengthError=1 sticky; data still delivered; the next correct 42-bot series does not clear the flag.
5. Continuous 42-bot series with botOutReady toggling 1,0,1,0.
   Expect: no reordering; botOut stable while stalled; occupancy returns to 0; completedSeries matches the series count.
6. Assert rst for 1 cycle mid-series with 20 entries buffered.
   Expect: the next cycle has botOutValid=0, occupancy=0, and all flags/counters 0; a fresh 42-bot series then passes without seriesLengthError.
